// File: rtl/usart_apb_sequencer_if.sv
// APB3 register-port bundle between the sequencer (master) and one USART (slave).
// Address is 3 bits wide, covering SR, DR, BRR, CR1 and CR2.
interface usart_apb_sequencer_if;
    logic [2:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/usart_apb_sequencer.sv
// APB3 master that configures one USART, round-robins TX bytes from NREQ requesters and drains RX into a stream.
// Latency: 6 cycles for init, 3 cycles per TX byte, 4 cycles per RX byte (SR + DR); each PREADY=0 cycle adds one.
// Backpressure: TX grants are paced by TX-FIFO credits; RX polling pauses while rx_valid waits on rx_ready.
module usart_apb_sequencer #(
    parameter int          NREQ        = 2,
    parameter logic [15:0] BRR_INIT    = 16'h0364,
    parameter logic [15:0] CR2_INIT    = 16'h0000,
    parameter logic [15:0] CR1_INIT    = 16'h202C,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] BYTE_CYCLES = 16'd868
) (
    input  logic                  io_apb_PCLK,
    input  logic                  io_apb_PRESET,
    usart_apb_sequencer_if.master m,
    input  logic                  irq,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_payload,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rx_valid,
    output logic [7:0]            rx_payload,
    input  logic                  rx_ready,
    output logic                  init_done
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

    localparam logic [2:0] ADDR_SR  = 3'b000;
    localparam logic [2:0] ADDR_DR  = 3'b001;
    localparam logic [2:0] ADDR_BRR = 3'b010;
    localparam logic [2:0] ADDR_CR1 = 3'b011;
    localparam logic [2:0] ADDR_CR2 = 3'b100;

    typedef enum logic [2:0] {
        INIT_BRR,
        INIT_CR2,
        INIT_CR1,
        IDLE,
        TX_DR,
        RX_SR,
        RX_DR
    } state_t;

    state_t          state_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [2:0]      paddr_q;
    logic [31:0]     pwdata_q;
    logic [IDXW-1:0] grant_q;
    logic [IDXW-1:0] rr_last_q;
    logic [CW-1:0]   credits_q;
    logic [15:0]     timer_q;

    logic            gnt_found;
    logic [IDXW-1:0] gnt_idx;
    logic [IDXW-1:0] rr_cand;
    logic            xfer_done;
    logic            tx_done;
    logic            refill;
    logic            unused_prdata;

    assign m.PSEL    = psel_q;
    assign m.PENABLE = penable_q;
    assign m.PWRITE  = pwrite_q;
    assign m.PADDR   = paddr_q;
    assign m.PWDATA  = pwdata_q;

    assign unused_prdata = ^m.PRDATA[31:8];

    assign xfer_done = psel_q && penable_q && m.PREADY;
    assign tx_done   = xfer_done && (state_q == TX_DR);
    assign refill    = (credits_q < CRED_MAX) && (timer_q == BYTE_CYCLES - 16'd1);

    // Search starts one past the last granted index so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand = IDXW'((int'(rr_last_q) + k) % NREQ);
            if (!gnt_found && req_valid[rr_cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_cand;
            end
        end
    end

    // Accept pulse follows PREADY combinationally so it lands on the completing ACCESS cycle only.
    always_comb begin
        req_ready = '0;
        if (!io_apb_PRESET && tx_done) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge io_apb_PCLK) begin
        if (io_apb_PRESET) begin
            credits_q <= CRED_MAX;
            timer_q   <= '0;
        end else begin
            if (credits_q == CRED_MAX || refill) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 16'd1;
            end
            if (refill && !tx_done) begin
                credits_q <= credits_q + CW'(1);
            end else if (!refill && tx_done) begin
                credits_q <= credits_q - CW'(1);
            end
        end
    end

    always_ff @(posedge io_apb_PCLK) begin
        if (io_apb_PRESET) begin
            state_q    <= INIT_BRR;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            grant_q    <= '0;
            rr_last_q  <= IDXW'(NREQ - 1);
            rx_valid   <= 1'b0;
            rx_payload <= '0;
            init_done  <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (state_q == IDLE) begin
                if (irq && !rx_valid) begin
                    state_q  <= RX_SR;
                    psel_q   <= 1'b1;
                    pwrite_q <= 1'b0;
                    paddr_q  <= ADDR_SR;
                end else if (gnt_found && credits_q != '0) begin
                    state_q  <= TX_DR;
                    psel_q   <= 1'b1;
                    pwrite_q <= 1'b1;
                    paddr_q  <= ADDR_DR;
                    pwdata_q <= {24'h0, req_payload[{gnt_idx, 3'b000} +: 8]};
                    grant_q  <= gnt_idx;
                end
            end else if (!psel_q) begin
                // Only reachable straight out of reset: launch the BRR write.
                psel_q   <= 1'b1;
                pwrite_q <= 1'b1;
                paddr_q  <= ADDR_BRR;
                pwdata_q <= {16'h0, BRR_INIT};
            end else if (!penable_q) begin
                penable_q <= 1'b1;
            end else if (m.PREADY) begin
                penable_q <= 1'b0;
                case (state_q)
                    INIT_BRR: begin
                        state_q  <= INIT_CR2;
                        paddr_q  <= ADDR_CR2;
                        pwdata_q <= {16'h0, CR2_INIT};
                    end
                    INIT_CR2: begin
                        state_q  <= INIT_CR1;
                        paddr_q  <= ADDR_CR1;
                        pwdata_q <= {16'h0, CR1_INIT};
                    end
                    INIT_CR1: begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        init_done <= 1'b1;
                    end
                    TX_DR: begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        rr_last_q <= grant_q;
                    end
                    RX_SR: begin
                        // RXNE chains straight into the DR read with no idle gap.
                        if (m.PRDATA[5]) begin
                            state_q <= RX_DR;
                            paddr_q <= ADDR_DR;
                        end else begin
                            state_q <= IDLE;
                            psel_q  <= 1'b0;
                        end
                    end
                    RX_DR: begin
                        state_q    <= IDLE;
                        psel_q     <= 1'b0;
                        rx_payload <= m.PRDATA[7:0];
                        rx_valid   <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        psel_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usart_apb_sequencer.sv
// Bench for usart_apb_sequencer: APB slave model plus a scoreboard of expected APB transfers and RX bytes.
module tb_usart_apb_sequencer;

    localparam int NREQ = 2;

    typedef struct {
        logic            wr;
        logic [2:0]      addr;
        logic [31:0]     data;
        logic [NREQ-1:0] rdy;
    } apb_exp_t;

    logic              clk;
    logic              rst;
    logic              irq;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_payload;
    logic [NREQ-1:0]   req_ready;
    logic              rx_valid;
    logic [7:0]        rx_payload;
    logic              rx_ready;
    logic              init_done;
    logic              pready_drv;
    logic [31:0]       sr_val;
    logic [31:0]       dr_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;

    apb_exp_t exp_q[$];
    logic [7:0] rx_q[$];
    int done_cyc[$];
    apb_exp_t mon_e;
    logic [7:0] mon_b;

    usart_apb_sequencer_if apb();

    assign apb.PREADY = pready_drv;
    assign apb.PRDATA = (apb.PADDR == 3'd0) ? sr_val :
                        (apb.PADDR == 3'd1) ? dr_val : 32'h0;

    usart_apb_sequencer #(
        .NREQ        (NREQ),
        .BRR_INIT    (16'h0364),
        .CR2_INIT    (16'h0000),
        .CR1_INIT    (16'h202C),
        .FIFO_DEPTH  (16),
        .BYTE_CYCLES (16'd100)
    ) dut (
        .io_apb_PCLK   (clk),
        .io_apb_PRESET (rst),
        .m             (apb),
        .irq           (irq),
        .req_valid     (req_valid),
        .req_payload   (req_payload),
        .req_ready     (req_ready),
        .rx_valid      (rx_valid),
        .rx_payload    (rx_payload),
        .rx_ready      (rx_ready),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [2:0] addr, input logic [31:0] data, input logic [NREQ-1:0] rdy);
        apb_exp_t e;
        e.wr = 1'b1; e.addr = addr; e.data = data; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [2:0] addr);
        apb_exp_t e;
        e.wr = 1'b0; e.addr = addr; e.data = 32'h0; e.rdy = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed transfer is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && apb.PSEL && apb.PENABLE && apb.PREADY) begin
            chk("apb_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("apb_write", 64'(apb.PWRITE), 64'(mon_e.wr));
                chk("apb_addr", 64'(apb.PADDR), 64'(mon_e.addr));
                if (mon_e.wr) chk("apb_wdata", 64'(apb.PWDATA), 64'(mon_e.data));
                chk("req_ready", 64'(req_ready), 64'(mon_e.rdy));
            end
            if (apb.PWRITE && apb.PADDR == 3'd1) begin
                done_cyc.push_back(cyc);
                if (req_ready[0]) acc_cnt++;
            end
            if (!apb.PWRITE) rd_cnt++;
        end else if (req_ready != '0) begin
            chk("req_ready_spurious", 64'(req_ready), 64'd0);
        end
        if (!rst && rx_valid && rx_ready) begin
            chk("rx_expected", 64'(rx_q.size() > 0), 64'd1);
            if (rx_q.size() > 0) begin
                mon_b = rx_q.pop_front();
                chk("rx_byte", 64'(rx_payload), 64'(mon_b));
            end
        end
    end

    task automatic reset_and_init(input string tag);
        rst = 1'b1; pready_drv = 1'b1; req_valid = '0; irq = 1'b0; rx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_psel"}, 64'(apb.PSEL), 64'd0);
        chk({tag, "_penable"}, 64'(apb.PENABLE), 64'd0);
        chk({tag, "_pwrite"}, 64'(apb.PWRITE), 64'd0);
        chk({tag, "_paddr"}, 64'(apb.PADDR), 64'd0);
        chk({tag, "_pwdata"}, 64'(apb.PWDATA), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
        chk({tag, "_rx_payload"}, 64'(rx_payload), 64'd0);
        chk({tag, "_init_done"}, 64'(init_done), 64'd0);
        push_wr(3'b010, 32'h0000_0364, '0);
        push_wr(3'b100, 32'h0000_0000, '0);
        push_wr(3'b011, 32'h0000_202C, '0);
        tick();
        rst = 1'b0;
        tick();
        chk({tag, "_brr_setup_psel"}, 64'(apb.PSEL), 64'd1);
        chk({tag, "_brr_setup_penable"}, 64'(apb.PENABLE), 64'd0);
        chk({tag, "_brr_setup_paddr"}, 64'(apb.PADDR), 64'd2);
        repeat (5) tick();
        chk({tag, "_init_done_c6"}, 64'(init_done), 64'd0);
        tick();
        chk({tag, "_init_done_c7"}, 64'(init_done), 64'd1);
        chk({tag, "_idle_psel"}, 64'(apb.PSEL), 64'd0);
        chk({tag, "_init_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        int d;
        rst = 1'b1; irq = 1'b0; req_valid = '0; req_payload = '0; rx_ready = 1'b0;
        pready_drv = 1'b1; sr_val = 32'h0; dr_val = 32'h0;

        reset_and_init("rst1");

        // Two requesters held valid: strict alternation, one byte every 3 cycles.
        done_cyc.delete();
        push_wr(3'd1, 32'hA1, 2'b01);
        push_wr(3'd1, 32'hB2, 2'b10);
        push_wr(3'd1, 32'hA1, 2'b01);
        push_wr(3'd1, 32'hB2, 2'b10);
        req_payload = {8'hB2, 8'hA1};
        req_valid = 2'b11;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        req_valid = '0;
        chk("rr_all_sent", 64'(exp_q.size()), 64'd0);
        chk("rr_count", 64'(done_cyc.size()), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (done_cyc.size() > i) chk("rr_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd3);
        end

        repeat (450) tick();

        // Credit exhaustion: 16 back-to-back writes, then refill-paced.
        done_cyc.delete();
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) push_wr(3'd1, 32'(8'hC0 + 8'(i)), 2'b01);
        req_payload = {8'h00, 8'hC0};
        req_valid = 2'b01;
        n = 0;
        while (exp_q.size() != 0 && n < 1500) begin
            tick();
            req_payload[7:0] = 8'hC0 + 8'(acc_cnt);
            n++;
        end
        req_valid = '0;
        chk("credit_all_sent", 64'(exp_q.size()), 64'd0);
        chk("credit_count", 64'(done_cyc.size()), 64'd20);
        if (done_cyc.size() >= 17) begin
            for (int i = 1; i < 16; i++) chk("credit_b2b", 64'(done_cyc[i] - done_cyc[i-1]), 64'd3);
            d = done_cyc[16] - done_cyc[0];
            chk("credit_refill_min", 64'(d >= 100), 64'd1);
            chk("credit_refill_max", 64'(d <= 106), 64'd1);
        end

        // RX with a stalled consumer: one SR+DR, then no polling while the byte is held.
        sr_val = 32'h20; dr_val = 32'h5A; rx_ready = 1'b0;
        push_rd(3'd0);
        push_rd(3'd1);
        rx_q.push_back(8'h5A);
        base = rd_cnt;
        irq = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        chk("rx_reads_done", 64'(exp_q.size()), 64'd0);
        repeat (20) tick();
        chk("rx_valid_hold", 64'(rx_valid), 64'd1);
        chk("rx_payload_hold", 64'(rx_payload), 64'h5A);
        chk("rx_no_repoll", 64'(rd_cnt - base), 64'd2);
        irq = 1'b0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_consumed", 64'(rx_q.size()), 64'd0);
        chk("rx_valid_clear", 64'(rx_valid), 64'd0);

        // IRQ and TX together: SR read (RXNE clear, no DR read) comes before the TX write.
        sr_val = 32'h0;
        push_rd(3'd0);
        push_wr(3'd1, 32'h77, 2'b10);
        req_payload = {8'h77, 8'h00};
        base = rd_cnt;
        req_valid = 2'b10;
        irq = 1'b1;
        n = 0;
        while (rd_cnt == base && n < 100) begin tick(); n++; end
        irq = 1'b0;
        chk("rx_before_tx", 64'(exp_q.size()), 64'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        req_valid = '0;
        chk("tx_after_rx", 64'(exp_q.size()), 64'd0);

        // Stalled TX write, requester withdraws, then reset mid-transfer.
        pready_drv = 1'b0;
        req_payload = {8'h00, 8'h99};
        req_valid = 2'b01;
        n = 0;
        while (!(apb.PSEL && apb.PWRITE && apb.PADDR == 3'd1) && n < 300) begin tick(); n++; end
        chk("stall_setup_seen", 64'(apb.PSEL && apb.PADDR == 3'd1), 64'd1);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_penable", 64'(apb.PENABLE), 64'd1);
            chk("stall_paddr", 64'(apb.PADDR), 64'd1);
            chk("stall_pwdata", 64'(apb.PWDATA), 64'h99);
        end
        reset_and_init("rst2");

        repeat (5) tick();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usart_apb_sequencer.md
# usart_apb_sequencer

APB3 master that owns the register port of one Apb3USART instance. After reset it programs BRR, CR2 and CR1. It then shares the USART transmitter between `NREQ` byte-stream requesters using round-robin arbitration, paced by a TX-FIFO credit counter. It also services the USART interrupt by polling SR and draining DR into an RX output stream. It sits between the client logic and the USART slave, and is the only APB master on that slave.

## Interface
Parameters:
- `NREQ`, 2: number of TX requesters (1..8).
- `BRR_INIT`, 16'h0364: value written to BRR (address 3'b010).
- `CR2_INIT`, 16'h0000: value written to CR2 (address 3'b100).
- `CR1_INIT`, 16'h202C: value written to CR1 (address 3'b011); sets UE, TE, RE and RXNEIE.
- `FIFO_DEPTH`, 16: USART TX FIFO depth; this is the maximum number of credits.
- `BYTE_CYCLES`, 16'd868: clock cycles per transmitted frame; one credit is refilled per period.

Ports:
- `io_apb_PCLK`  in  1  clock; the only clock.
- `io_apb_PRESET`  in  1  reset, synchronous, active-high.
- `m_PADDR`  out  3  USART register address.
- `m_PSEL`  out  1  APB select.
- `m_PENABLE`  out  1  APB enable.
- `m_PWRITE`  out  1  APB write.
- `m_PWDATA`  out  32  write data; bits 31:16 are always 0.
- `m_PREADY`  in  1  slave ready.
- `m_PRDATA`  in  32  slave read data.
- `irq`  in  1  USART interrupt, level-sensitive.
- `req_valid`  in  NREQ  TX byte valid, one bit per requester.
- `req_payload`  in  8*NREQ  TX bytes; requester i uses bits [8i+7:8i].
- `req_ready`  out  NREQ  one-cycle accept pulse per requester.
- `rx_valid`  out  1  received byte available.
- `rx_payload`  out  8  received byte.
- `rx_ready`  in  1  RX consumer ready.
- `init_done`  out  1  high once the configuration sequence has completed.

## Operation
- States: INIT_BRR, INIT_CR2, INIT_CR1, IDLE, TX_DR, RX_SR, RX_DR.
- Every non-IDLE state performs one APB transfer:
  - SETUP cycle: PSEL=1, PENABLE=0.
  - ACCESS cycle: PSEL=1, PENABLE=1; repeated while PREADY=0.
  - The transfer completes on the ACCESS cycle where PREADY=1.
  - PADDR, PWRITE and PWDATA are held stable from SETUP through completion.
- Init writes: BRR_INIT, then CR2_INIT, then CR1_INIT, then IDLE. `init_done` goes to 1 on CR1 completion and stays 1 until reset.
- IDLE decision, evaluated in one cycle (PSEL=0), in priority order:
  1. If `irq`=1 and `rx_valid`=0: go to RX_SR.
  2. Else if any `req_valid` bit is set and credits>0: grant a requester round-robin, starting from the index after the last granted one (the pointer resets to NREQ-1, so requester 0 wins first). Latch its payload and go to TX_DR.
  3. Else stay in IDLE.
- TX_DR writes {24'b0, byte} to address 3'b001. On completion:
  - `req_ready[grant]`=1 for that single cycle.
  - Credits decrement by 1.
  - The round-robin pointer moves to the granted index.
  - Next state is IDLE.
- RX_SR reads address 3'b000.
  - If PRDATA[5] (RXNE)=1: go to RX_DR.
  - Otherwise: go to IDLE.
- RX_DR reads address 3'b001. On completion, `rx_payload`=PRDATA[7:0] and `rx_valid`=1.
  - The byte is held until `rx_valid`&`rx_ready`; `rx_valid` clears on the following cycle.
  - Next state is IDLE.
- Credits:
  - The counter ranges 0..FIFO_DEPTH and resets to FIFO_DEPTH.
  - The refill timer counts only while credits<FIFO_DEPTH.
  - At BYTE_CYCLES-1 the timer wraps to 0 and credits increment by 1.
  - The timer clears when credits reach FIFO_DEPTH.
  - A refill and a consume in the same cycle give a net change of 0.
  - Credits never underflow, because a TX grant requires credits>0.
- A `req_valid` that drops after a grant does not cancel the write; the latched byte is still sent.

## Timing
- Reset values:
  - APB outputs: `m_PSEL`=0, `m_PENABLE`=0, `m_PWRITE`=0, `m_PADDR`=0, `m_PWDATA`=0.
  - Streams and status: `req_ready`=0, `rx_valid`=0, `rx_payload`=0, `init_done`=0.
  - State: INIT_BRR, with credits at FIFO_DEPTH.
- BRR SETUP is on the first cycle after reset deasserts.
- With PREADY=1, init completes in 6 cycles and `init_done` is high on cycle 7.
- TX latency with PREADY=1: IDLE (grant) to SETUP to ACCESS is 3 cycles per byte. `req_ready` is high in the ACCESS cycle.
- RX latency: RX_SR takes 2 cycles and RX_DR takes 2 cycles. `rx_valid` rises on the cycle after DR completes.
- Each PREADY=0 cycle extends the current state by one cycle.
- Reset asserted mid-transfer: at the next edge PSEL and PENABLE go to 0, the state returns to INIT_BRR and the full init sequence repeats.

## Test plan
- Reset release with PREADY=1 -> writes BRR=0x0364, CR2=0x0000, CR1=0x202C in order, 2 cycles each; `init_done`=1 on cycle 7.
- `req_valid`=2'b11 held, bytes 0xA1 (req0) and 0xB2 (req1), credits plentiful -> DR writes 0xA1, 0xB2, 0xA1, 0xB2, one every 3 cycles; the `req_ready` pulses alternate between requesters.
- BYTE_CYCLES=100, req0 offers 20 bytes continuously -> 16 writes back-to-back; the 17th write is no earlier than 100 cycles after credits first fell below 16.
- `irq`=1, SR read returns 0x20, DR read returns 0x5A, `rx_ready`=0 -> `rx_valid`=1 with 0x5A. No further SR read occurs until `rx_ready` is pulsed.
- `irq`=1, SR read returns 0x0000 -> no DR read; FSM returns to IDLE. With `irq` and a TX request pending together, RX is serviced first.
- PREADY held 0 for 3 cycles during TX_DR, then reset asserted -> PADDR and PWDATA stay stable during the wait; after reset PSEL=0, no `req_ready` pulse, and init restarts with BRR.
